crc32_fcs_append: RTL



---
 rtl/crc32_fcs_append.sv | 107 ++++++++++
 1 files changed

// File: rtl/crc32_fcs_append.sv
// Byte-stream frame stage: passes payload through, zero-pads short frames and
// appends the reflected CRC-32 FCS (complemented, LSB byte first).
module crc32_fcs_append #(
  parameter logic [31:0] POLY    = 32'hEDB88320,
  parameter logic [31:0] INIT    = 32'hFFFFFFFF,
  parameter int unsigned MIN_LEN = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last
);

  typedef enum logic [2:0] {DATA, PAD, FCS0, FCS1, FCS2, FCS3} state_t;

  state_t      state;
  logic [31:0] crc;
  logic [15:0] count;
  logic        free;
  logic [7:0]  crc_in;
  logic [31:0] crc_next;
  logic [16:0] count_inc;
  logic [15:0] count_next;
  logic        need_pad;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ POLY;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign free       = !out_valid || out_ready;
  assign in_ready   = !reset && (state == DATA) && free;
  assign crc_in     = (state == DATA) ? in_data : 8'h00;
  assign crc_next   = crc_byte(crc, crc_in);
  assign count_inc  = {1'b0, count} + 17'd1;
  assign count_next = (count == 16'hFFFF) ? count : count_inc[15:0];
  // The pad decision uses the unsaturated length of the frame so far.
  assign need_pad   = {15'd0, count_inc} < MIN_LEN;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= DATA;
      crc       <= INIT;
      count     <= 16'd0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
    end else if (free) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      case (state)
        DATA: begin
          if (in_valid) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            crc       <= crc_next;
            count     <= count_next;
            if (in_last) state <= need_pad ? PAD : FCS0;
          end
        end
        PAD: begin
          out_data  <= 8'h00;
          out_valid <= 1'b1;
          crc       <= crc_next;
          count     <= count_next;
          if (!need_pad) state <= FCS0;
        end
        FCS0: begin
          out_data  <= ~crc[7:0];
          out_valid <= 1'b1;
          state     <= FCS1;
        end
        FCS1: begin
          out_data  <= ~crc[15:8];
          out_valid <= 1'b1;
          state     <= FCS2;
        end
        FCS2: begin
          out_data  <= ~crc[23:16];
          out_valid <= 1'b1;
          state     <= FCS3;
        end
        FCS3: begin
          out_data  <= ~crc[31:24];
          out_valid <= 1'b1;
          out_last  <= 1'b1;
          crc       <= INIT;
          count     <= 16'd0;
          state     <= DATA;
        end
        default: state <= DATA;
      endcase
    end
  end

endmodule
